btb_upd_ctrl: RTL and testbench

Update controller for the branch target buffer. It shares the BTB's single resolution write port between `N_SRC` branch-resolution producers using round-robin arbitration with a valid/ready handshake, and registers the selected update toward the BTB. It also sequences BTB flushes and keeps saturating update and delete statistics. It sits between the execute-stage branch units and the BTB, and drives the BTB's `valid_i`, `del_entry_i`, `res_i` and `flush_i` inputs.

---
 rtl/mmm_pkg.sv | 17 +
 rtl/btb_upd_ctrl_rr_arbiter.sv | 41 ++++
 rtl/btb_upd_ctrl.sv | 101 ++++++++++
 tb/tb_btb_upd_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mmm_pkg.sv
// Shared front-end types: branch resolution record and BTB update controller states.
package mmm_pkg;
  localparam int XLEN     = 32;
  localparam int BTB_BITS = 8;
  localparam int OFFSET   = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } resolution_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2
  } btb_ctrl_state_t;
endpackage

// File: rtl/btb_upd_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer (with
// wrap-around); the pointer moves past the winner only when advance is asserted.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_nxt;
  logic          w_found;
  int            w_idx;

  // Rotating priority search starting at the pointer
  always_comb begin
    gnt     = '0;
    w_nxt   = r_ptr;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        w_nxt      = (w_idx == N - 1) ? '0 : PW'(w_idx + 1);
      end
    end
  end

  // Pointer steps past the winner only on an accepted grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        r_ptr <= '0;
    else if (advance) r_ptr <= w_nxt;
  end
endmodule

// File: rtl/btb_upd_ctrl.sv
// BTB update controller: arbitrates resolution producers onto the single BTB
// write port, sequences flushes and keeps saturating update/delete counters.
module btb_upd_ctrl
  import mmm_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_SRC-1:0]        src_valid_i,
  input  logic [N_SRC-1:0]        src_del_i,
  input  resolution_t [N_SRC-1:0] src_res_i,
  output logic [N_SRC-1:0]        src_ready_o,
  input  logic                    flush_req_i,
  output logic                    flush_done_o,
  output logic                    btb_valid_o,
  output logic                    btb_del_entry_o,
  output resolution_t             btb_res_o,
  output logic                    btb_flush_o,
  output logic [CNT_W-1:0]        upd_cnt_o,
  output logic [CNT_W-1:0]        del_cnt_o
);
  btb_ctrl_state_t r_state;
  logic [N_SRC-1:0] w_gnt;
  logic             w_run;
  logic             w_hs;
  logic             w_sel_del;
  resolution_t      w_sel_res;

  // A flush request wins over arbitration in the very cycle it is seen; reset
  // also masks ready so every output reads 0 while rst_i is high.
  assign w_run       = (r_state == RUN) && !flush_req_i && !rst_i;
  assign src_ready_o = w_gnt & {N_SRC{w_run}};
  assign w_hs        = |src_ready_o;

  rr_arbiter #(.N(N_SRC)) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (src_valid_i),
    .advance (w_hs),
    .gnt     (w_gnt)
  );

  // Select the accepted source's payload (ready is one-hot)
  always_comb begin
    w_sel_res = '0;
    w_sel_del = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_ready_o[i]) begin
        w_sel_res = src_res_i[i];
        w_sel_del = src_del_i[i];
      end
    end
  end

  // Flush sequencer: RUN -> FLUSH -> SETTLE -> RUN, re-flush allowed from SETTLE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= RUN;
    else begin
      case (r_state)
        RUN:     if (flush_req_i) r_state <= FLUSH;
        FLUSH:   r_state <= SETTLE;
        SETTLE:  r_state <= flush_req_i ? FLUSH : RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  assign btb_flush_o  = (r_state == FLUSH);
  assign flush_done_o = (r_state == SETTLE) && !flush_req_i;

  // Registered update toward the BTB; data holds when idle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btb_valid_o     <= 1'b0;
      btb_del_entry_o <= 1'b0;
      btb_res_o       <= '0;
    end else begin
      btb_valid_o <= w_hs;
      if (w_hs) begin
        btb_del_entry_o <= w_sel_del;
        btb_res_o       <= w_sel_res;
      end
    end
  end

  // Saturating statistics, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      upd_cnt_o <= '0;
      del_cnt_o <= '0;
    end else if (btb_valid_o) begin
      if (btb_del_entry_o) begin
        if (del_cnt_o != '1) del_cnt_o <= del_cnt_o + 1'b1;
      end else begin
        if (upd_cnt_o != '1) upd_cnt_o <= upd_cnt_o + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_btb_upd_ctrl.sv
// Directed bench for btb_upd_ctrl (N_SRC=2, CNT_W=4 so saturation is reachable).
module tb_btb_upd_ctrl;
  import mmm_pkg::*;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [1:0]        src_valid_i = '0;
  logic [1:0]        src_del_i = '0;
  resolution_t [1:0] src_res_i = '0;
  logic [1:0]        src_ready_o;
  logic              flush_req_i = 1'b0;
  logic              flush_done_o;
  logic              btb_valid_o;
  logic              btb_del_entry_o;
  resolution_t       btb_res_o;
  logic              btb_flush_o;
  logic [3:0]        upd_cnt_o;
  logic [3:0]        del_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  btb_upd_ctrl #(.N_SRC(2), .CNT_W(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .src_valid_i     (src_valid_i),
    .src_del_i       (src_del_i),
    .src_res_i       (src_res_i),
    .src_ready_o     (src_ready_o),
    .flush_req_i     (flush_req_i),
    .flush_done_o    (flush_done_o),
    .btb_valid_o     (btb_valid_o),
    .btb_del_entry_o (btb_del_entry_o),
    .btb_res_o       (btb_res_o),
    .btb_flush_o     (btb_flush_o),
    .upd_cnt_o       (upd_cnt_o),
    .del_cnt_o       (del_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; src_valid_i = '0; src_del_i = '0; flush_req_i = 1'b0; src_res_i = '0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_cmp++; if ({src_ready_o, flush_done_o, btb_valid_o, btb_del_entry_o, btb_flush_o, upd_cnt_o, del_cnt_o} !== '0) begin n_bad++; $display("FAIL reset_outs: got %h want 0", {src_ready_o, flush_done_o, btb_valid_o, btb_del_entry_o, btb_flush_o, upd_cnt_o, del_cnt_o}); end
    n_cmp++; if (btb_res_o !== '0) begin n_bad++; $display("FAIL reset_res: got %h want 0", btb_res_o); end
    // release and stream from source 0
    @(negedge clk);
    rst_i = 1'b0; src_valid_i = 2'b01; src_res_i[0].pc = 32'hA0; src_res_i[0].target = 32'hB0;
    #1;
    n_cmp++; if (src_ready_o !== 2'b01) begin n_bad++; $display("FAIL rst_first_ready: got %b want 01", src_ready_o); end
    @(negedge clk); #1;
    n_cmp++; if (btb_valid_o !== 1'b1) begin n_bad++; $display("FAIL rst_stream_valid: got %b want 1", btb_valid_o); end
    // mid-stream reset: outputs clear immediately
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    n_cmp++; if ({src_ready_o, btb_valid_o, upd_cnt_o} !== '0) begin n_bad++; $display("FAIL rst_mid_outs: got %h want 0", {src_ready_o, btb_valid_o, upd_cnt_o}); end
    n_cmp++; if (btb_res_o !== '0) begin n_bad++; $display("FAIL rst_mid_res: got %h want 0", btb_res_o); end
    // pointer was 1 before reset; it must restart at 0
    @(negedge clk);
    rst_i = 1'b0; src_valid_i = 2'b11;
    #1;
    n_cmp++; if (src_ready_o !== 2'b01) begin n_bad++; $display("FAIL rst_ptr_zero: got %b want 01", src_ready_o); end
  endtask

  task automatic test_single();
    resolution_t exp;
    exp.pc = 32'h0000_1000; exp.target = 32'h0000_2000;
    do_reset();
    src_valid_i = 2'b10; src_del_i = 2'b00; src_res_i[1] = exp;
    #1;
    n_cmp++; if (src_ready_o !== 2'b10) begin n_bad++; $display("FAIL single_ready: got %b want 10", src_ready_o); end
    @(negedge clk);
    src_valid_i = '0;
    #1;
    n_cmp++; if (btb_valid_o !== 1'b1 || btb_del_entry_o !== 1'b0) begin n_bad++; $display("FAIL single_valid: got v=%b d=%b want v=1 d=0", btb_valid_o, btb_del_entry_o); end
    n_cmp++; if (btb_res_o !== exp) begin n_bad++; $display("FAIL single_res: got %h want %h", btb_res_o, exp); end
    @(negedge clk); #1;
    n_cmp++; if (btb_valid_o !== 1'b0 || upd_cnt_o !== 4'd1 || btb_res_o !== exp) begin n_bad++; $display("FAIL single_after: got v=%b cnt=%0d res=%h want v=0 cnt=1 res=%h", btb_valid_o, upd_cnt_o, btb_res_o, exp); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    src_res_i[0].pc = 32'h100; src_res_i[0].target = 32'h200;
    src_res_i[1].pc = 32'h300; src_res_i[1].target = 32'h400;
    src_valid_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (src_ready_o !== exp_rdy[k]) begin n_bad++; $display("FAIL cont_ready[%0d]: got %b want %b", k, src_ready_o, exp_rdy[k]); end
      n_cmp++; if (btb_valid_o !== (k != 0)) begin n_bad++; $display("FAIL cont_valid[%0d]: got %b want %b", k, btb_valid_o, (k != 0)); end
      if (k != 0) begin
        n_cmp++; if (btb_res_o.pc !== ((k % 2 == 1) ? 32'h100 : 32'h300)) begin n_bad++; $display("FAIL cont_res[%0d]: got %h", k, btb_res_o.pc); end
      end
      @(negedge clk);
    end
    src_valid_i = '0;
    #1;
    n_cmp++; if (btb_valid_o !== 1'b1 || btb_res_o.pc !== 32'h300) begin n_bad++; $display("FAIL cont_last: got v=%b pc=%h want v=1 pc=300", btb_valid_o, btb_res_o.pc); end
    @(negedge clk); #1;
    n_cmp++; if (btb_valid_o !== 1'b0 || upd_cnt_o !== 4'd4) begin n_bad++; $display("FAIL cont_cnt: got v=%b cnt=%0d want v=0 cnt=4", btb_valid_o, upd_cnt_o); end
  endtask

  task automatic test_delete();
    do_reset();
    src_valid_i = 2'b01; src_del_i = 2'b01;
    src_res_i[0].pc = 32'h0000_1004; src_res_i[0].target = 32'h0;
    #1;
    n_cmp++; if (src_ready_o !== 2'b01) begin n_bad++; $display("FAIL del_ready: got %b want 01", src_ready_o); end
    @(negedge clk);
    src_valid_i = '0; src_del_i = '0;
    #1;
    n_cmp++; if (btb_valid_o !== 1'b1 || btb_del_entry_o !== 1'b1 || btb_res_o.pc !== 32'h1004) begin n_bad++; $display("FAIL del_out: got v=%b d=%b pc=%h want 1 1 1004", btb_valid_o, btb_del_entry_o, btb_res_o.pc); end
    @(negedge clk); #1;
    n_cmp++; if (del_cnt_o !== 4'd1 || upd_cnt_o !== 4'd0) begin n_bad++; $display("FAIL del_cnt: got del=%0d upd=%0d want 1 0", del_cnt_o, upd_cnt_o); end
  endtask

  task automatic test_flush();
    do_reset();
    src_valid_i = 2'b11;
    #1;  // t-1: source 0 accepted
    n_cmp++; if (src_ready_o !== 2'b01) begin n_bad++; $display("FAIL fl_pre_ready: got %b want 01", src_ready_o); end
    @(negedge clk);
    flush_req_i = 1'b1;
    #1;  // t
    n_cmp++; if (src_ready_o !== 2'b00 || btb_flush_o !== 1'b0 || btb_valid_o !== 1'b1) begin n_bad++; $display("FAIL fl_t: got rdy=%b fl=%b v=%b want 00 0 1", src_ready_o, btb_flush_o, btb_valid_o); end
    @(negedge clk);
    flush_req_i = 1'b0;
    #1;  // t+1
    n_cmp++; if (src_ready_o !== 2'b00 || btb_flush_o !== 1'b1 || flush_done_o !== 1'b0 || btb_valid_o !== 1'b0) begin n_bad++; $display("FAIL fl_t1: got rdy=%b fl=%b dn=%b v=%b want 00 1 0 0", src_ready_o, btb_flush_o, flush_done_o, btb_valid_o); end
    @(negedge clk); #1;  // t+2
    n_cmp++; if (src_ready_o !== 2'b00 || btb_flush_o !== 1'b0 || flush_done_o !== 1'b1) begin n_bad++; $display("FAIL fl_t2: got rdy=%b fl=%b dn=%b want 00 0 1", src_ready_o, btb_flush_o, flush_done_o); end
    @(negedge clk); #1;  // t+3: pointer is 1 after the pre-flush grant
    n_cmp++; if (src_ready_o !== 2'b10 || flush_done_o !== 1'b0) begin n_bad++; $display("FAIL fl_t3: got rdy=%b dn=%b want 10 0", src_ready_o, flush_done_o); end
  endtask

  task automatic test_back_to_back_flush();
    do_reset();
    src_valid_i = 2'b11; flush_req_i = 1'b1;  // t
    @(negedge clk);
    flush_req_i = 1'b0;                       // t+1
    #1;
    n_cmp++; if (btb_flush_o !== 1'b1) begin n_bad++; $display("FAIL bb_t1: got fl=%b want 1", btb_flush_o); end
    @(negedge clk);
    flush_req_i = 1'b1;                       // t+2
    #1;
    n_cmp++; if (flush_done_o !== 1'b0 || src_ready_o !== 2'b00 || btb_flush_o !== 1'b0) begin n_bad++; $display("FAIL bb_t2: got dn=%b rdy=%b fl=%b want 0 00 0", flush_done_o, src_ready_o, btb_flush_o); end
    @(negedge clk);
    flush_req_i = 1'b0;                       // t+3
    #1;
    n_cmp++; if (btb_flush_o !== 1'b1 || src_ready_o !== 2'b00) begin n_bad++; $display("FAIL bb_t3: got fl=%b rdy=%b want 1 00", btb_flush_o, src_ready_o); end
    @(negedge clk); #1;                       // t+4
    n_cmp++; if (flush_done_o !== 1'b1 || src_ready_o !== 2'b00) begin n_bad++; $display("FAIL bb_t4: got dn=%b rdy=%b want 1 00", flush_done_o, src_ready_o); end
    @(negedge clk); #1;                       // t+5
    n_cmp++; if (src_ready_o !== 2'b01) begin n_bad++; $display("FAIL bb_t5: got rdy=%b want 01", src_ready_o); end
    @(negedge clk);
    src_valid_i = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    src_valid_i = 2'b01; src_del_i = 2'b00;
    for (int k = 0; k < 17; k++) begin
      src_res_i[0].pc = 32'(k);
      @(negedge clk);
    end
    src_valid_i = '0;
    @(negedge clk);
    @(negedge clk); #1;
    n_cmp++; if (upd_cnt_o !== 4'd15 || del_cnt_o !== 4'd0) begin n_bad++; $display("FAIL sat_cnt: got upd=%0d del=%0d want 15 0", upd_cnt_o, del_cnt_o); end
    n_cmp++; if (btb_res_o.pc !== 32'd16) begin n_bad++; $display("FAIL sat_last_res: got %h want 10", btb_res_o.pc); end
    // a flush leaves the statistics intact
    flush_req_i = 1'b1;
    @(negedge clk);
    flush_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    n_cmp++; if (upd_cnt_o !== 4'd15) begin n_bad++; $display("FAIL sat_after_flush: got %0d want 15", upd_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_delete();
    test_flush();
    test_back_to_back_flush();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
